// File: rtl/fbuf_pkg.sv
// Shared definitions for the frame-buffer arbiter slice.
//   - default address / pixel widths
//   - grant-state encoding for the arbiter FSM
//   - saturating increment helper for the forced-write counter
package fbuf_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 9;

  // Grant encoding is chosen so that each RAM control output is a single
  // state bit: bit0 = mem_en, bit1 = mem_we, bit2 = vga_miss.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_READ  = 3'b001,
    S_WRITE = 3'b011,
    S_FORCE = 3'b111
  } grant_e;

  localparam logic [15:0] OVF_MAX = 16'hFFFF;

  // Increment a 16-bit counter, holding at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == OVF_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fbuf_wfifo.sv
// Camera write queue: synchronous FIFO of {addr,data} entries.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties queue)
//   push, push_addr,  enqueue one entry (ignored when full)
//   push_data
//   pop               dequeue the head entry (ignored when empty)
//   head_addr/data    current head entry, valid while !empty
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module fbuf_wfifo
  import fbuf_pkg::*;
#(
  parameter int AW    = ADDR_W_DEF,
  parameter int DW    = DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]     wr_ptr_r;
  logic [PTR_W:0]     rd_ptr_r;
  logic [AW+DW-1:0]   store_r [DEPTH];
  logic               push_s;
  logic               pop_s;

  assign count     = wr_ptr_r - rd_ptr_r;
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push_s    = push & ~full;
  assign pop_s     = pop & ~empty;
  assign head_addr = store_r[rd_ptr_r[PTR_W-1:0]][AW+DW-1:DW];
  assign head_data = store_r[rd_ptr_r[PTR_W-1:0]][DW-1:0];

  // Pointer update; reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      end
    end
  end

  // Entry storage; contents only matter while occupied, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      store_r[wr_ptr_r[PTR_W-1:0]] <= {push_addr, push_data};
    end
  end

endmodule

// File: rtl/fbuf_arbiter.sv
// Frame-buffer RAM arbiter: shares one single-port RAM between the VGA
// scan-out reader (fixed latency, priority) and the camera writer (queued).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   vga_req, vga_addr        read request / address, sampled every cycle
//   vga_q, vga_q_valid       read data, valid MEM_LAT+2 cycles after request
//   vga_miss                 1-cycle pulse when a read slot was taken by a forced write
//   cam_wen, cam_addr,       camera write request; accepted on cam_wen & cam_ready
//   cam_data, cam_ready
//   mem_en, mem_we,          registered RAM strobe / write enable / address / data
//   mem_addr, mem_wdata
//   mem_rdata                RAM read data, MEM_LAT cycles after mem_en
//   ovf_cnt                  saturating count of forced writes
module fbuf_arbiter
  import fbuf_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_q,
  output logic              vga_q_valid,
  output logic              vga_miss,
  input  logic              cam_wen,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       ovf_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_MAX) + 1;

  grant_e            state_s;
  grant_e            state_r;
  logic [2:0]        grant_bits_s;
  logic [SC_W-1:0]   starve_s;
  logic [SC_W-1:0]   starve_r;
  logic              pop_s;
  logic              push_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [CNT_W-1:0]  occ_next_s;
  logic [MEM_LAT:0]  rd_pipe_r;

  assign push_s = cam_wen & cam_ready;

  fbuf_wfifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_addr (cam_addr),
    .push_data (cam_data),
    .pop       (pop_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Grant decision for this cycle plus starvation bookkeeping.
  always_comb begin
    state_s  = S_IDLE;
    pop_s    = 1'b0;
    starve_s = '0;
    if (vga_req && fifo_full_s && (starve_r == SC_W'(STARVE_MAX - 1))) begin
      // The queue has been full and blocked long enough: steal this read slot.
      state_s  = S_FORCE;
      pop_s    = 1'b1;
      starve_s = '0;
    end else if (vga_req) begin
      state_s = S_READ;
      if (fifo_full_s) begin
        starve_s = starve_r + SC_W'(1);
      end else begin
        starve_s = '0;
      end
    end else if (!fifo_empty_s) begin
      state_s = S_WRITE;
      pop_s   = 1'b1;
    end else begin
      state_s = S_IDLE;
    end
  end

  // Grant state and starve counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      starve_r <= '0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
    end
  end

  // Strobes come straight from grant-state flop bits (see encoding).
  assign grant_bits_s = state_r;
  assign mem_en       = grant_bits_s[0];
  assign mem_we       = grant_bits_s[1];
  assign vga_miss     = grant_bits_s[2];

  // RAM address / write-data registers; hold their value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_s)
        S_READ: begin
          mem_addr <= vga_addr;
        end
        S_WRITE, S_FORCE: begin
          mem_addr  <= head_addr_s;
          mem_wdata <= head_data_s;
        end
        default: begin
          mem_addr  <= mem_addr;
          mem_wdata <= mem_wdata;
        end
      endcase
    end
  end

  // Read tag pipe: bit i set means RAM data for a read lands i cycles from now
  // relative to mem_en; the last stage lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_r <= '0;
    end else begin
      rd_pipe_r[0] <= (state_s == S_READ);
      for (int i = 1; i <= MEM_LAT; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // Read data capture; vga_q keeps the last delivered pixel between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_q       <= '0;
      vga_q_valid <= 1'b0;
    end else begin
      vga_q_valid <= rd_pipe_r[MEM_LAT];
      if (rd_pipe_r[MEM_LAT]) begin
        vga_q <= mem_rdata;
      end else begin
        vga_q <= vga_q;
      end
    end
  end

  assign occ_next_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);

  // cam_ready tracks next-cycle occupancy, so it drops right after the filling accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_ready <= 1'b1;
    end else begin
      cam_ready <= (occ_next_s != CNT_W'(FIFO_DEPTH));
    end
  end

  // Forced-write counter, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= 16'd0;
    end else if (state_s == S_FORCE) begin
      ovf_cnt <= sat_inc16(ovf_cnt);
    end else begin
      ovf_cnt <= ovf_cnt;
    end
  end

endmodule

// File: tb/tb_fbuf_arbiter.sv
// Self-checking bench for fbuf_arbiter with a behavioural 1-cycle RAM.
module tb_fbuf_arbiter;

  localparam int AW = 17;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_q;
  logic          vga_q_valid;
  logic          vga_miss;
  logic          cam_wen = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [DW-1:0] cam_data = '0;
  logic          cam_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   ovf_cnt;

  always #5 clk = ~clk;

  fbuf_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .MEM_LAT(1), .STARVE_MAX(16)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_q(vga_q),
    .vga_q_valid(vga_q_valid), .vga_miss(vga_miss),
    .cam_wen(cam_wen), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_ready(cam_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ovf_cnt(ovf_cnt)
  );

  // Behavioural single-port RAM, read latency 1.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  int rd_seen  = 0;

  logic [DW-1:0]    rd_q [$];
  logic [AW+DW-1:0] wr_q [$];
  logic [DW-1:0]    shadow [logic [AW-1:0]];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: RAM writes and read returns, in order.
  always @(negedge clk) begin
    logic [AW+DW-1:0] we_e;
    logic [DW-1:0]    re_e;
    if (mem_en && mem_we) begin
      wr_seen++;
      chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        we_e = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(we_e[AW+DW-1:DW]));
        chk("wr_data", 32'(mem_wdata), 32'(we_e[DW-1:0]));
      end
    end
    if (vga_q_valid) begin
      rd_seen++;
      chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        re_e = rd_q.pop_front();
        chk("rd_data", 32'(vga_q), 32'(re_e));
      end
    end
  end

  // Drive one cycle of inputs and record what the DUT must later produce.
  task automatic drive(input logic vr, input logic [AW-1:0] va, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic skip_rd, output logic acc);
    vga_req  = vr;
    vga_addr = va;
    cam_wen  = we;
    cam_addr = wa;
    cam_data = wd;
    acc = we && cam_ready;
    if (acc) begin
      wr_q.push_back({wa, wd});
      shadow[wa] = wd;
    end
    if (vr && !skip_rd) rd_q.push_back(shadow.exists(va) ? shadow[va] : '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"},    32'(mem_en), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_vga_q"},     32'(vga_q), 32'd0);
    chk({tag, "_vga_valid"}, 32'(vga_q_valid), 32'd0);
    chk({tag, "_vga_miss"},  32'(vga_miss), 32'd0);
    chk({tag, "_ovf_cnt"},   32'(ovf_cnt), 32'd0);
    chk({tag, "_cam_ready"}, 32'(cam_ready), 32'd1);
  endtask

  typedef struct {
    logic          vr;
    logic [AW-1:0] va;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_valid;
    logic [DW-1:0] e_q;
    logic          e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic vr, input logic [AW-1:0] va, input logic we,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic e_en, input logic e_we, input logic [AW-1:0] e_addr,
                              input logic [DW-1:0] e_wd, input logic e_valid,
                              input logic [DW-1:0] e_q);
    vec_t v;
    v.vr = vr; v.va = va; v.we = we; v.wa = wa; v.wd = wd;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_valid = e_valid; v.e_q = e_q; v.e_rdy = 1'b1;
    return v;
  endfunction

  initial begin
    vec_t          vecs [11];
    logic          acc;
    int            idx;
    int            wr_base;
    int            rd_base;

    // Write drain (rows 0..5), then a read of address 5 (rows 6..10).
    vecs[0]  = mk(1'b0, 17'h0,   1'b1, 17'h10,  9'h1A5, 1'b0, 1'b0, 17'h0,   9'h0,   1'b0, 9'h0);
    vecs[1]  = mk(1'b0, 17'h0,   1'b1, 17'h11,  9'h0F0, 1'b0, 1'b0, 17'h0,   9'h0,   1'b0, 9'h0);
    vecs[2]  = mk(1'b0, 17'h0,   1'b1, 17'h12,  9'h007, 1'b1, 1'b1, 17'h10,  9'h1A5, 1'b0, 9'h0);
    vecs[3]  = mk(1'b0, 17'h0,   1'b1, 17'h5,   9'h0AB, 1'b1, 1'b1, 17'h11,  9'h0F0, 1'b0, 9'h0);
    vecs[4]  = mk(1'b0, 17'h0,   1'b1, 17'h100, 9'h055, 1'b1, 1'b1, 17'h12,  9'h007, 1'b0, 9'h0);
    vecs[5]  = mk(1'b0, 17'h0,   1'b0, 17'h0,   9'h0,   1'b1, 1'b1, 17'h5,   9'h0AB, 1'b0, 9'h0);
    vecs[6]  = mk(1'b1, 17'h5,   1'b0, 17'h0,   9'h0,   1'b1, 1'b1, 17'h100, 9'h055, 1'b0, 9'h0);
    vecs[7]  = mk(1'b0, 17'h0,   1'b0, 17'h0,   9'h0,   1'b1, 1'b0, 17'h5,   9'h0,   1'b0, 9'h0);
    vecs[8]  = mk(1'b0, 17'h0,   1'b0, 17'h0,   9'h0,   1'b0, 1'b0, 17'h0,   9'h0,   1'b0, 9'h0);
    vecs[9]  = mk(1'b0, 17'h0,   1'b0, 17'h0,   9'h0,   1'b0, 1'b0, 17'h0,   9'h0,   1'b1, 9'h0AB);
    vecs[10] = mk(1'b0, 17'h0,   1'b0, 17'h0,   9'h0,   1'b0, 1'b0, 17'h0,   9'h0,   1'b0, 9'h0AB);

    // ---- 1: reset state, idle after release, mid-clock reset ----
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_mem_en", 32'(mem_en), 32'd0);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 17'h40, 9'h111, 1'b0, acc);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
    @(negedge clk);
    chk("t1_we_before_rst", 32'(mem_we), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("t1_async_rst");
    wr_q.delete();
    rd_q.delete();
    shadow.delete(17'h40);
    @(negedge clk);
    rst = 1'b0;

    // ---- 2/3: table-driven write drain and read latency ----
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      if (vecs[i].e_en) chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we) chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wd));
      chk($sformatf("vec%0d_valid", i), 32'(vga_q_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_vga_q", i), 32'(vga_q), 32'(vecs[i].e_q));
      chk($sformatf("vec%0d_ready", i), 32'(cam_ready), 32'(vecs[i].e_rdy));
      drive(vecs[i].vr, vecs[i].va, vecs[i].we, vecs[i].wa, vecs[i].wd, 1'b0, acc);
    end

    // ---- 4: read priority, full FIFO, forced write ----
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 4) chk("t4_ready_low", 32'(cam_ready), 32'd0);
      if (c >= 1 && c <= 19) chk("t4_no_we_blocked", 32'(mem_we), 32'd0);
      if (c == 20) begin
        chk("t4_force_we", 32'(mem_we), 32'd1);
        chk("t4_force_addr", 32'(mem_addr), 32'h20);
        chk("t4_miss", 32'(vga_miss), 32'd1);
        chk("t4_ovf", 32'(ovf_cnt), 32'd1);
        chk("t4_ready_back", 32'(cam_ready), 32'd1);
      end
      if (c == 21) chk("t4_miss_pulse", 32'(vga_miss), 32'd0);
      if (c == 22) chk("t4_no_valid_forced", 32'(vga_q_valid), 32'd0);
      drive(1'b1, 17'h100, c < 4, 17'(32'h20 + c), 9'(32'h120 + c), c == 19, acc);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
    repeat (10) @(negedge clk);
    chk("t4_wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("t4_rd_q_empty", 32'(rd_q.size()), 32'd0);

    // ---- 5: full boundary with held cam_wen ----
    idx = 0;
    wr_base = wr_seen;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, 17'h100, 1'b1, 17'(32'h50 + idx), 9'(32'h150 + idx), 1'b0, acc);
      if (acc) idx++;
    end
    for (int c = 0; c < 40 && idx < 10; c++) begin
      @(negedge clk);
      drive(1'b0, '0, 1'b1, 17'(32'h50 + idx), 9'(32'h150 + idx), 1'b0, acc);
      if (acc) idx++;
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
    chk("t5_all_accepted", 32'(idx), 32'd10);
    repeat (10) @(negedge clk);
    chk("t5_write_count", 32'(wr_seen - wr_base), 32'd10);
    for (int a = 32'h50; a < 32'h5A; a++) begin
      chk($sformatf("t5_ram_%0h", a), 32'(ram[17'(a)]), 32'(shadow[17'(a)]));
    end

    // ---- 6: reset with queued writes and a read in flight ----
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, 17'h5, c < 3, 17'(32'h10 + c), 9'(32'h1F0 + c), 1'b0, acc);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("t6_async_rst");
    wr_q.delete();
    rd_q.delete();
    shadow[17'h10] = 9'h1A5;
    shadow[17'h11] = 9'h0F0;
    shadow[17'h12] = 9'h007;
    wr_base = wr_seen;
    rd_base = rd_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_we_after", 32'(wr_seen - wr_base), 32'd0);
    chk("t6_no_valid_after", 32'(rd_seen - rd_base), 32'd0);
    chk("t6_ram_10", 32'(ram[17'h10]), 32'h1A5);
    chk("t6_ram_11", 32'(ram[17'h11]), 32'h0F0);
    chk("t6_ram_12", 32'(ram[17'h12]), 32'h007);
    chk("t6_ovf_cleared", 32'(ovf_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
